seq_serializer: RTL and testbench

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_serializer.sv | 75 +++++++
 tb/tb_seq_serializer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// seq_pkg : shared frame-width default and IDLE/SHIFT state encoding
// Rev 1.0
// ============================================================================
package seq_pkg;

  localparam int c_seq_width = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
// seq_serializer : parallel word to MSB-first serial bit stream with handshake
// Rev 1.0
// ============================================================================
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = c_seq_width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [WIDTH-1:0]   r_sreg;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_last_bit;
  logic               w_accept;

  // The last-bit edge doubles as a load slot so frames can run back to back.
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == c_last) && shift_en;
  assign load_ready = (r_state == IDLE) || w_last_bit;
  assign w_accept   = load_valid && load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT:   if (w_last_bit && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_sreg <= load_data;
      r_cnt  <= '0;
    end else if ((r_state == SHIFT) && shift_en) begin
      r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
      r_cnt  <= w_last_bit ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

  // Outputs come only from registers, so reset clears them without a clock.
  assign x_valid     = (r_state == SHIFT);
  assign x           = x_valid & r_sreg[WIDTH-1];
  assign frame_start = x_valid && (r_cnt == '0);
  assign frame_done  = x_valid && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
// tb_seq_serializer : scoreboard bench, expected bit stream kept as a queue
// ============================================================================
module tb_seq_serializer;

  localparam int W = 32;

  typedef struct {
    logic b;
    int   idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         shift_en = 1'b0;
  logic         load_ready;
  logic         x;
  logic         x_valid;
  logic         frame_start;
  logic         frame_done;

  int   checks = 0;
  int   errors = 0;
  int   se_mode = 0;
  int   stall = 0;
  exp_t q[$];

  seq_serializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .shift_en    (shift_en),
    .x           (x),
    .x_valid     (x_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Model: the queue holds every bit still owed to the detector, in order.
  always begin
    @(negedge clk or posedge reset);
    if (reset) begin
      #1;
      q.delete();
      checks++;
      if ({x, x_valid, frame_start, frame_done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs t=%0t got x/xv/fs/fd=%b%b%b%b want 0000",
                 $time, x, x_valid, frame_start, frame_done);
      end
    end else begin
      logic m_ready;
      m_ready = (q.size() == 0) || ((q.size() == 1) && shift_en);
      checks++;
      if (load_ready !== m_ready) begin
        errors++;
        $display("FAIL load_ready t=%0t got %b want %b", $time, load_ready, m_ready);
      end
      if (q.size() == 0) begin
        checks++;
        if ({x, x_valid, frame_start, frame_done} !== 4'b0000) begin
          errors++;
          $display("FAIL idle_outputs t=%0t got x/xv/fs/fd=%b%b%b%b want 0000",
                   $time, x, x_valid, frame_start, frame_done);
        end
      end else begin
        logic ex, es, ed;
        ex = q[0].b;
        es = (q[0].idx == 0);
        ed = (q[0].idx == W - 1);
        checks++;
        if ({x, x_valid, frame_start, frame_done} !== {ex, 1'b1, es, ed}) begin
          errors++;
          $display("FAIL serial_bit t=%0t idx=%0d got x/xv/fs/fd=%b%b%b%b want %b1%b%b",
                   $time, q[0].idx, x, x_valid, frame_start, frame_done, ex, es, ed);
        end
        if (shift_en) void'(q.pop_front());
      end
      if (load_valid && m_ready) begin
        for (int i = 0; i < W; i++) q.push_back('{load_data[W-1-i], i});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall > 0) begin
      shift_en = 1'b0;
      stall--;
    end else begin
      shift_en = (se_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  endtask

  // Holds the word on load_data until the edge that takes it.
  task automatic send_word(input logic [W-1:0] w);
    load_valid = 1'b1;
    load_data  = w;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (load_ready && !reset) begin
        tick();
        load_valid = 1'b0;
        load_data  = W'($urandom);
        return;
      end
      tick();
    end
    $display("FAIL send_word_timeout word=%h not accepted within 300 cycles", w);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "handshake timeout");
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    load_valid = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!x_valid) return;
      tick();
    end
    $display("FAIL drain_timeout x_valid still high after 300 cycles");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "drain timeout");
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    shift_en = 1'b1;
    idle(2);

    // Single frame, shift_en held high.
    se_mode = 0;
    send_word(32'h4E525945);
    drain();
    idle(2);

    // Back to back: second word waits with load_valid high through the frame.
    send_word(32'h4E525945);
    send_word(32'hFFFF0000);
    drain();
    idle(2);

    // Three-cycle stall while bit index 5 is presented.
    send_word(32'h4E525945);
    repeat (4) tick();
    stall = 3;
    tick();
    drain();
    idle(2);

    // Asynchronous reset while bit index 12 is presented, then a fresh frame.
    send_word(32'h4E525945);
    repeat (12) tick();
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    send_word(32'hA5C30F81);
    drain();
    idle(2);

    // Randomized words, gaps and shift_en back-pressure.
    se_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
      send_word(W'($urandom));
    end
    se_mode = 0;
    drain();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
